reaction_game_core: RTL
=======================

Name: reaction_game_core

Overview:
Parametrised successor of the fixed 2-player/10-LED game controller. Runs one timed whack-a-mole round for NUM_PLAYERS players over NUM_TARGETS targets. Sits between the key-decode layer, which supplies per-player hit strobes, and the LED/7-seg display drivers. Player count, target count, round length and tick rate are generic; it adds simultaneous-hit arbitration, no-repeat targets and winner/tie reporting.

Parameters:
NUM_PLAYERS, 2, number of players (1..8)
NUM_TARGETS, 10, number of targets/LEDs (2..16)
SCORE_W, 7, per-player score width; scores saturate at 2^SCORE_W-1
GAME_SECONDS, 60, round length in seconds
TICKS_PER_SEC, 100000000, clk cycles per second; benches use 10
LFSR_SEED, 16'hACE1, nonzero reset seed of the 16-bit LFSR

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
start  in  1  one-cycle start pulse (debounced, edge-detected upstream)
difficulty  in  2  00=4s, 01=3s, 10=2s, 11=1s target window
hit_valid  in  NUM_PLAYERS  per-player one-cycle hit strobe
hit_num  in  4*NUM_PLAYERS  packed per-player target index, player p at [4p+3:4p]
target  out  NUM_TARGETS  one-hot lit target; all zero when no round is active
game_active  out  1  high while the round runs
time_left  out  8  whole seconds remaining
scores  out  SCORE_W*NUM_PLAYERS  packed scores, player p at [SCORE_W*p +: SCORE_W]
winner  out  3  index of the highest score, valid in OVER
tie  out  1  in OVER, high when two or more players share the top score

Behaviour:
- Reset (reset_n low at a clk edge): state IDLE; target=0, game_active=0, time_left=0, scores=0, winner=0, tie=0; LFSR=LFSR_SEED; all counters cleared. Reset overrides everything, including mid-round.
- The LFSR (x^16+x^14+x^13+x^11) advances every cycle in all states.
- States: IDLE, PLAY, OVER.
- IDLE/OVER + start: next cycle enters PLAY. Scores clear, time_left=GAME_SECONDS, difficulty is latched, a new target is drawn, and the window and second counters are zeroed.
- start in PLAY is ignored; difficulty changes during PLAY are ignored.
- Target draw: idx = lfsr mod NUM_TARGETS. If idx equals the current target, use (idx+1) mod NUM_TARGETS instead, so the same target never appears twice in a row.
- Second counter: wraps at TICKS_PER_SEC-1 and decrements time_left on each wrap. When time_left would go 1->0, the next state is OVER.
- OVER: target=0, game_active=0, scores held; winner/tie are registered on entry. winner is the lowest index among the tied maxima.
- Window counter: counts window_seconds*TICKS_PER_SEC cycles. On expiry it redraws the target with no score change.
- Hits (PLAY only), evaluated each cycle across all players:
  - Correct hit: hit_valid[p] and hit_num_p equals the current target index.
  - If one or more players hit correctly, only the lowest-indexed of them scores +1 (saturating). The other correct hitters get no change. The target is redrawn and the window counter restarts.
  - Wrong hit: hit_valid[p] and a mismatch, including hit_num_p >= NUM_TARGETS. It scores -1, saturating at 0. Wrong hits by different players in the same cycle are each applied.
  - Latency: score and target update are visible on the cycle after the strobe.
- Simultaneous events:
  - Game end and a hit in the same cycle: the end wins and the hit is discarded.
  - Window expiry and a correct hit in the same cycle: the hit is scored and a single redraw occurs.
- Hits in IDLE/OVER are ignored.

Optional Feature:
COMBO_BONUS_EN.
- Defined: a per-player streak counter (2 bits, saturating at 2) increments on each scored correct hit by that player.
  - A scored hit made while the streak is already 2 awards +2 instead of +1, still saturating.
  - A player's streak clears on that player's wrong hit, on another player scoring, on window expiry, and on start.
- Undefined: no streak logic; every scored hit is +1.

Test Plan:
- Reset then idle with hit_valid pulses -> scores=0, target=0, game_active=0 throughout.
- TICKS_PER_SEC=10, GAME_SECONDS=3, start -> game_active=1 next cycle, time_left=3; OVER reached exactly 30 cycles later with target=0.
- Player 1 hits the current index -> scores[1]=1 one cycle later and the target changes to a different one-hot value. Player 0 hits a wrong index twice from 0 -> score stays 0.
- Players 0 and 2 both hit correctly in the same cycle -> only player 0 gains 1; player 2 unchanged. Target changes.
- difficulty=11, no hits -> the target changes every 10 cycles, 1000 consecutive draws never repeat, all NUM_TARGETS indices occur.
- End with scores {3,5,5} -> winner=1, tie=1. Under COMBO_BONUS_EN, three consecutive scored hits by player 0 -> score 4.

Source files
------------

// File: rtl/reaction_game_core.sv
// reaction_game_core: one timed whack-a-mole round for NUM_PLAYERS players over NUM_TARGETS lit
// targets, with simultaneous-hit arbitration, no-repeat target draws and winner/tie reporting.
// Optional build macro COMBO_BONUS_EN: per-player hit streaks; a hit at streak 2 scores +2.
module reaction_game_core #(
  parameter int unsigned NUM_PLAYERS   = 2,
  parameter int unsigned NUM_TARGETS   = 10,
  parameter int unsigned SCORE_W       = 7,
  parameter int unsigned GAME_SECONDS  = 60,
  parameter int unsigned TICKS_PER_SEC = 100000000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                           i_clk,
  input  logic                           i_reset_n,
  input  logic                           i_start,
  input  logic [1:0]                     i_difficulty,
  input  logic [NUM_PLAYERS-1:0]         i_hit_valid,
  input  logic [4*NUM_PLAYERS-1:0]       i_hit_num,
  output logic [NUM_TARGETS-1:0]         o_target,
  output logic                           o_game_active,
  output logic [7:0]                     o_time_left,
  output logic [SCORE_W*NUM_PLAYERS-1:0] o_scores,
  output logic [2:0]                     o_winner,
  output logic                           o_tie
);

  localparam int unsigned SecW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned WinW = $clog2(4 * TICKS_PER_SEC + 1);
  localparam logic [SCORE_W-1:0] ScoreMax = '1;

  typedef enum logic [1:0] {StIdle, StPlay, StOver} state_e;

  state_e             r_state, w_state_next;
  logic [15:0]        r_lfsr, w_lfsr_next;
  logic [3:0]         r_target_idx, w_target_next;
  logic [1:0]         r_diff, w_diff_next;
  logic [7:0]         r_time_left, w_time_next;
  logic [SecW-1:0]    r_sec_cnt, w_sec_next;
  logic [WinW-1:0]    r_win_cnt, w_win_next;
  logic [SCORE_W-1:0] r_scores [NUM_PLAYERS];
  logic [SCORE_W-1:0] w_scores_next [NUM_PLAYERS];
  logic [2:0]         r_winner, w_winner_next;
  logic               r_tie, w_tie_next;
`ifdef COMBO_BONUS_EN
  logic [1:0]         r_streak [NUM_PLAYERS];
  logic [1:0]         w_streak_next [NUM_PLAYERS];
`endif

  logic [3:0]             w_draw_raw, w_draw_idx;
  logic                   w_sec_wrap, w_end, w_win_expire;
  logic [2:0]             w_win_secs;
  logic [WinW-1:0]        w_win_last;
  logic [NUM_PLAYERS-1:0] w_scorer_oh, w_wrong;
  logic                   w_any_score;
  logic [SCORE_W-1:0]     w_best;
  logic [2:0]             w_best_idx;
  logic                   w_best_tie;
  logic [1:0]             w_inc;

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s,
                                                 input logic [1:0] inc);
    logic [SCORE_W:0] sum;
    sum = {1'b0, s} + (SCORE_W+1)'(inc);
    return sum[SCORE_W] ? ScoreMax : sum[SCORE_W-1:0];
  endfunction

  // Fibonacci LFSR for x^16+x^14+x^13+x^11, free-running in every state
  assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

  assign w_draw_raw = 4'(r_lfsr % 16'(NUM_TARGETS));

  // Bump a draw that lands on the lit target to the next index so targets never repeat
  always_comb begin
    w_draw_idx = w_draw_raw;
    if (w_draw_raw == r_target_idx) begin
      w_draw_idx = (w_draw_raw == 4'(NUM_TARGETS - 1)) ? 4'd0 : w_draw_raw + 4'd1;
    end
  end

  assign w_sec_wrap   = (r_sec_cnt == SecW'(TICKS_PER_SEC - 1));
  assign w_end        = (r_state == StPlay) && w_sec_wrap && (r_time_left <= 8'd1);
  // Window length in seconds is 4 - difficulty
  assign w_win_secs   = {1'b0, ~r_diff} + 3'd1;
  assign w_win_last   = WinW'(w_win_secs) * WinW'(TICKS_PER_SEC) - WinW'(1);
  assign w_win_expire = (r_win_cnt == w_win_last);

  // Classify hits: only the lowest-indexed correct hitter scores, every wrong hitter loses one
  always_comb begin
    w_scorer_oh = '0;
    w_wrong     = '0;
    w_any_score = 1'b0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (i_hit_valid[p]) begin
        if (i_hit_num[4*p +: 4] == r_target_idx) begin
          if (!w_any_score) begin
            w_scorer_oh[p] = 1'b1;
            w_any_score    = 1'b1;
          end
        end else begin
          w_wrong[p] = 1'b1;
        end
      end
    end
  end

  // Top score search; ties keep the lowest index
  always_comb begin
    w_best     = r_scores[0];
    w_best_idx = 3'd0;
    w_best_tie = 1'b0;
    for (int p = 1; p < NUM_PLAYERS; p++) begin
      if (r_scores[p] > w_best) begin
        w_best     = r_scores[p];
        w_best_idx = 3'(p);
        w_best_tie = 1'b0;
      end else if (r_scores[p] == w_best) begin
        w_best_tie = 1'b1;
      end
    end
  end

  // Round sequencing, scoring and target redraw
  always_comb begin
    w_state_next  = r_state;
    w_target_next = r_target_idx;
    w_diff_next   = r_diff;
    w_time_next   = r_time_left;
    w_sec_next    = r_sec_cnt;
    w_win_next    = r_win_cnt;
    w_scores_next = r_scores;
    w_winner_next = r_winner;
    w_tie_next    = r_tie;
    w_inc         = 2'd1;
`ifdef COMBO_BONUS_EN
    w_streak_next = r_streak;
`endif
    case (r_state)
      StIdle, StOver: begin
        if (i_start) begin
          w_state_next  = StPlay;
          w_scores_next = '{default: '0};
          w_time_next   = 8'(GAME_SECONDS);
          w_diff_next   = i_difficulty;
          w_target_next = w_draw_idx;
          w_sec_next    = '0;
          w_win_next    = '0;
          w_winner_next = 3'd0;
          w_tie_next    = 1'b0;
`ifdef COMBO_BONUS_EN
          w_streak_next = '{default: '0};
`endif
        end
      end
      StPlay: begin
        w_sec_next = w_sec_wrap ? '0 : r_sec_cnt + SecW'(1);
        if (w_sec_wrap) begin
          w_time_next = r_time_left - 8'd1;
        end
        if (w_end) begin
          // Round end beats any hit in the same cycle
          w_state_next  = StOver;
          w_winner_next = w_best_idx;
          w_tie_next    = w_best_tie;
        end else begin
          for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (w_scorer_oh[p]) begin
`ifdef COMBO_BONUS_EN
              w_inc = (r_streak[p] == 2'd2) ? 2'd2 : 2'd1;
              w_streak_next[p] = (r_streak[p] == 2'd2) ? 2'd2 : r_streak[p] + 2'd1;
`endif
              w_scores_next[p] = sat_add(r_scores[p], w_inc);
            end else begin
              if (w_wrong[p] && (r_scores[p] != '0)) begin
                w_scores_next[p] = r_scores[p] - SCORE_W'(1);
              end
`ifdef COMBO_BONUS_EN
              if (w_wrong[p] || w_any_score || w_win_expire) begin
                w_streak_next[p] = 2'd0;
              end
`endif
            end
          end
          // A correct hit and a window expiry together still give a single redraw
          if (w_any_score || w_win_expire) begin
            w_target_next = w_draw_idx;
            w_win_next    = '0;
          end else begin
            w_win_next = r_win_cnt + WinW'(1);
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state      <= StIdle;
      r_lfsr       <= LFSR_SEED;
      r_target_idx <= 4'd0;
      r_diff       <= 2'd0;
      r_time_left  <= 8'd0;
      r_sec_cnt    <= '0;
      r_win_cnt    <= '0;
      r_scores     <= '{default: '0};
      r_winner     <= 3'd0;
      r_tie        <= 1'b0;
`ifdef COMBO_BONUS_EN
      r_streak     <= '{default: '0};
`endif
    end else begin
      r_state      <= w_state_next;
      r_lfsr       <= w_lfsr_next;
      r_target_idx <= w_target_next;
      r_diff       <= w_diff_next;
      r_time_left  <= w_time_next;
      r_sec_cnt    <= w_sec_next;
      r_win_cnt    <= w_win_next;
      r_scores     <= w_scores_next;
      r_winner     <= w_winner_next;
      r_tie        <= w_tie_next;
`ifdef COMBO_BONUS_EN
      r_streak     <= w_streak_next;
`endif
    end
  end

  assign o_game_active = (r_state == StPlay);
  assign o_target      = o_game_active ? ({{(NUM_TARGETS-1){1'b0}}, 1'b1} << r_target_idx) : '0;
  assign o_time_left   = r_time_left;
  assign o_winner      = r_winner;
  assign o_tie         = r_tie;

  // Flatten per-player scores onto the packed output bus
  always_comb begin
    o_scores = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      o_scores[SCORE_W*p +: SCORE_W] = r_scores[p];
    end
  end

endmodule
